// File: rtl/load_store_unit.sv
// load_store_unit: single-port SRAM access engine for a core.
//   Accepts one request at a time (req/we/size/sign_ld/addr/wdata), checks
//   alignment and range, and runs one of:
//     fault          : IDLE -> DONE
//     load           : IDLE -> RD -> DONE
//     word store     : IDLE -> WR -> DONE
//     sub-word store : IDLE -> RD -> WR -> DONE   (read-modify-write)
//   Ports:
//     clk, rst (async, active low)
//     req, we, size, sign_ld, addr, wdata : request from the core
//     busy, done, fault, rdata            : status / load result to the core
//     sram_addr, w_sram, w_sram_en        : word-aligned memory port
//     r_sram                              : combinational read data at sram_addr
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] sram_addr,
  output logic [31:0] w_sram,
  output logic        w_sram_en,
  input  logic [31:0] r_sram
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nxt;
  // Only the lane bits and low data half are needed after accept: the
  // aligned address goes straight to sram_addr and word-store data
  // straight to w_sram.
  logic [1:0]  a_lane;
  logic [1:0]  a_size;
  logic        a_we;
  logic        a_sign;
  logic [15:0] a_wdata;
  logic        flt_q;

  logic        req_fault;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_val;
  logic [31:0] st_merge;

  always_comb begin
    req_fault = (size == 2'b11) || (addr >= ADDR_LIMIT) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) begin
        if (req_fault)          state_nxt = DONE;
        else if (!we)           state_nxt = RD;
        else if (size == 2'b10) state_nxt = WR;
        else                    state_nxt = RD;   // sub-word store reads first
      end
      RD:      state_nxt = a_we ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    fault     = (state == DONE) && flt_q;
    w_sram_en = (state == WR);
  end

  // lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    case (a_lane)
      2'd0:    rd_byte = r_sram[7:0];
      2'd1:    rd_byte = r_sram[15:8];
      2'd2:    rd_byte = r_sram[23:16];
      default: rd_byte = r_sram[31:24];
    endcase
    rd_half = a_lane[1] ? r_sram[31:16] : r_sram[15:0];
    case (a_size)
      2'b00:   ld_val = {{24{a_sign & rd_byte[7]}}, rd_byte};
      2'b01:   ld_val = {{16{a_sign & rd_half[15]}}, rd_half};
      default: ld_val = r_sram;
    endcase
    st_merge = r_sram;
    if (a_size == 2'b00) st_merge[{a_lane, 3'b000} +: 8]        = a_wdata[7:0];
    else                 st_merge[{a_lane[1], 4'b0000} +: 16]   = a_wdata;
  end

  // request latch and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_lane    <= 2'b00;
      a_size    <= 2'b00;
      a_we      <= 1'b0;
      a_sign    <= 1'b0;
      a_wdata   <= 16'h0;
      flt_q     <= 1'b0;
      rdata     <= 32'h0;
      sram_addr <= 32'h0;
      w_sram    <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req) begin
          a_lane    <= addr[1:0];
          a_size    <= size;
          a_we      <= we;
          a_sign    <= sign_ld;
          a_wdata   <= wdata[15:0];
          flt_q     <= req_fault;
          sram_addr <= {addr[31:2], 2'b00};
          if (we && size == 2'b10 && !req_fault) w_sram <= wdata;
        end
        RD: begin
          if (a_we) w_sram <= st_merge;
          else      rdata  <= ld_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses, checked against an array-based memory/result reference model.
module tb_load_store_unit;
  localparam logic [31:0] LIM = 32'h0000_1000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, done, fault, w_sram_en;
  logic [31:0] rdata, sram_addr, w_sram, r_sram;

  logic [31:0] mem     [0:1023];   // SRAM the DUT talks to
  logic [31:0] ref_mem [0:1023];   // reference memory image
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] last_w = 32'h0;
  int          wr_cnt = 0;
  int          n_chk = 0, n_bad = 0;

  load_store_unit #(.ADDR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ld(sign_ld),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .sram_addr(sram_addr), .w_sram(w_sram),
    .w_sram_en(w_sram_en), .r_sram(r_sram)
  );

  always #5 clk = ~clk;

  assign r_sram = mem[sram_addr[11:2]];

  always @(posedge clk) begin
    if (w_sram_en) begin
      mem[sram_addr[11:2]] <= w_sram;
      last_w <= w_sram;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: apply one access to ref_mem / exp_rdata, return fault,
  // accept-to-done latency and number of memory writes.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic f, output int lat, output int nw);
    int unsigned sh;
    logic [31:0] word, v, m;
    word = ref_mem[a[11:2]];
    f = (sz == 2'd3) || (a >= LIM) || (sz == 2'd1 && a[0]) ||
        (sz == 2'd2 && a[1:0] != 2'd0);
    nw = 0;
    if (f) lat = 1;
    else if (!w) begin
      lat = 2;
      if (sz == 2'd0) begin
        sh = 8 * a[1:0];
        v = (word >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        sh = 16 * a[1];
        v = (word >> sh) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else v = word;
      exp_rdata = v;
    end else begin
      nw = 1;
      if (sz == 2'd2) begin
        lat = 2;
        ref_mem[a[11:2]] = wd;
      end else begin
        lat = 3;
        if (sz == 2'd0) begin sh = 8 * a[1:0];  m = 32'hFF << sh; end
        else            begin sh = 16 * a[1];   m = 32'hFFFF << sh; end
        ref_mem[a[11:2]] = (word & ~m) | ((wd << sh) & m);
      end
    end
  endtask

  task automatic do_acc(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic ef, gf;
    int el, nw, lat, w0;
    model(w, sz, sg, a, wd, ef, el, nw);
    w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ld = sg; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      // scramble the request bus while busy; latched fields must not move
      we = 1'($urandom); size = 2'($urandom); sign_ld = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    gf = fault;
    chk({tag, ".lat"}, 32'(lat), 32'(el));
    chk({tag, ".fault"}, {31'h0, gf}, {31'h0, ef});
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".writes"}, 32'(wr_cnt - w0), 32'(nw));
    chk({tag, ".mem"}, mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  initial begin
    int dn, idl, w0;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h8899_AABB; ref_mem[16] = 32'h8899_AABB;

    // reset state
    #12;
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.fault", {31'h0, fault}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.sram_addr", sram_addr, 32'h0);
    chk("rst.w_sram", w_sram, 32'h0);
    chk("rst.wen", {31'h0, w_sram_en}, 32'h0);
    @(negedge clk); rst = 1'b1;

    // byte load with sign extension
    do_acc(1'b0, 2'd0, 1'b1, 32'h42, 32'h0, "ld_b_s");
    chk("ld_b_s.const", rdata, 32'hFFFF_FF99);
    // halfword read-modify-write
    do_acc(1'b1, 2'd1, 1'b0, 32'h40, 32'h0000_1234, "st_h");
    chk("st_h.wdata", last_w, 32'h8899_1234);
    chk("st_h.memc", mem[16], 32'h8899_1234);
    // word store then loads
    do_acc(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEAD_BEEF, "st_w");
    do_acc(1'b0, 2'd2, 1'b1, 32'h80, 32'h0, "ld_w");
    chk("ld_w.const", rdata, 32'hDEAD_BEEF);
    do_acc(1'b0, 2'd1, 1'b0, 32'h82, 32'h0, "ld_h_z");
    chk("ld_h_z.const", rdata, 32'h0000_DEAD);
    // faults
    do_acc(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, "flt_align");
    do_acc(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1111_2222, "flt_range");
    do_acc(1'b1, 2'd3, 1'b0, 32'h10, 32'h3333_4444, "flt_size");
    chk("flt.const", rdata, 32'h0000_DEAD);

    // req held high: accepts every third cycle (IDLE, RD, DONE)
    @(negedge clk);
    w0 = wr_cnt;
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ld = 1'b0; addr = 32'h80;
    dn = 0; idl = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (!busy) idl++;
    end
    req = 1'b0;
    exp_rdata = ref_mem[32];
    chk("b2b.dones", 32'(dn), 32'd4);
    chk("b2b.idle", 32'(idl), 32'd4);
    chk("b2b.rdata", rdata, exp_rdata);
    chk("b2b.writes", 32'(wr_cnt - w0), 32'd0);

    // reset during RD of a byte store
    @(negedge clk);
    w0 = wr_cnt;
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ld = 1'b0; addr = 32'h45; wdata = 32'h5A;
    @(negedge clk);
    req = 1'b0;
    chk("abort.inrd", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    exp_rdata = 32'h0;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.wen", {31'h0, w_sram_en}, 32'h0);
    chk("abort.rdata", rdata, 32'h0);
    chk("abort.sram_addr", sram_addr, 32'h0);
    chk("abort.w_sram", w_sram, 32'h0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    chk("abort.nodone", 32'(dn), 32'd0);
    chk("abort.writes", 32'(wr_cnt - w0), 32'd0);
    chk("abort.mem", mem[17], ref_mem[17]);
    do_acc(1'b0, 2'd0, 1'b0, 32'h45, 32'h0, "post_rst");

    // random traffic over a small window so stores and loads collide
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = LIM + $urandom_range(0, 255);
      else                           a = $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      do_acc(1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
